axis_sample_dropper: RTL and testbench
======================================

# axis_sample_dropper

Source-side counterpart of the sink-side zero-filling stage. It accepts a free-running AXI4-Stream that cannot be stalled, such as ADC samples, and presents it to a consumer that may apply backpressure. A small first-word-fall-through FIFO absorbs short stalls. When the FIFO is full, samples are dropped rather than replaced, and every drop is counted and flagged so software can detect data loss.

## Interface
Parameters:
- AXIS_TDATA_WIDTH, 32, sample width in bits
- FIFO_ADDR_WIDTH, 4, log2 of FIFO depth (depth = 2^FIFO_ADDR_WIDTH = 16)
- CNTR_WIDTH, 32, width of drop counter

Ports:
- aclk  in  1  system clock; all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- s_axis_tready  out  1  0 while areset is high, 1 otherwise; the source is never stalled
- s_axis_tdata  in  AXIS_TDATA_WIDTH  input sample
- s_axis_tvalid  in  1  input sample present
- m_axis_tready  in  1  consumer ready
- m_axis_tdata  out  AXIS_TDATA_WIDTH  FIFO head word
- m_axis_tvalid  out  1  FIFO not empty
- clear  in  1  synchronous; clears drop_count and overflow
- drop_count  out  CNTR_WIDTH  number of dropped samples, saturating
- overflow  out  1  sticky; set by any drop
- fill_level  out  FIFO_ADDR_WIDTH+1  words currently held (0..depth)

## Operation
- Read: when m_axis_tvalid and m_axis_tready are both high, the head word is consumed and the read pointer advances.
- Write: when s_axis_tvalid is high, the sample is written if the FIFO is not full, or if it is full and a read occurs in the same cycle.
- Drop: when s_axis_tvalid is high, the FIFO is full and no read occurs, the sample is discarded.
  - drop_count increments and saturates at all-ones.
  - overflow is set to 1.
- Pointers are FIFO_ADDR_WIDTH+1 bits with an extra wrap bit.
  - Empty: wr_ptr == rd_ptr.
  - Full: the MSBs differ and the lower bits are equal.
  - Pointers wrap modulo 2^(FIFO_ADDR_WIDTH+1).
- fill_level = wr_ptr - rd_ptr, computed modulo 2^(FIFO_ADDR_WIDTH+1), registered.
- clear:
  - With no drop in the same cycle: drop_count becomes 0 and overflow becomes 0.
  - With a drop in the same cycle: drop_count becomes 1 and overflow stays 1, so the event is not lost.
  - clear never flushes FIFO contents.
- Samples arriving while areset is high are discarded and not counted.
- There is no state machine. Control is two pointers, a counter and a flag.

## Timing
- Reset values (asynchronous, while areset is high):
  - m_axis_tvalid = 0, m_axis_tdata = 0, drop_count = 0, overflow = 0, fill_level = 0, s_axis_tready = 0.
  - Both pointers are 0.
  - Memory contents are not reset.
- Latency: a sample accepted at edge N appears on m_axis_tdata with m_axis_tvalid = 1 after edge N (first-word fall-through). No combinational path exists from s_axis_* to m_axis_*.
- m_axis_tvalid and m_axis_tdata hold stable while m_axis_tready is low.
- m_axis_tready low for k cycles with continuous input: the first depth samples are stored, and the following k - depth samples are dropped (if k > depth).
- Throughput: one write and one read per cycle, including when full or empty.
- Simultaneous read and write:
  - When empty: the new word is written. The read is a no-op because m_axis_tvalid is 0 in that cycle.
  - When full: both occur and fill_level is unchanged.
- Reset mid-stream: all state is discarded immediately. The output returns to empty with no glitching valid.

## Structure
- No shared package is needed. Depth and pointer widths are derived locally from FIFO_ADDR_WIDTH.
- Sub-module axis_sample_dropper_ram: a simple dual-port register array with synchronous write and asynchronous read at rd_ptr[FIFO_ADDR_WIDTH-1:0], targeted at distributed RAM.
- Top level holds the pointers, full/empty logic, drop counter, overflow flag and fill_level.

## Test plan
- Reset then continuous input 1,2,3… with m_axis_tready = 1 -> output 1,2,3… one cycle late; fill_level ≤ 1; drop_count = 0.
- m_axis_tready = 0 for 20 cycles with continuous input, depth 16 -> fill_level = 16, drop_count = 4, overflow = 1; after release the output is the first 16 samples in order, with no gaps.
- FIFO full and m_axis_tready = 1 with continuous input -> no drops; fill_level stays 16; order is preserved across pointer wrap (run 100 words).
- clear asserted in the same cycle as a drop -> drop_count = 1, overflow = 1; clear alone on the next cycle -> 0, 0; FIFO contents unchanged.
- CNTR_WIDTH = 4 with 20 forced drops -> drop_count saturates at 15.
- areset asserted with 10 words stored -> next cycle m_axis_tvalid = 0, fill_level = 0; after release the first new input is output first.

Source files
------------

// File: rtl/axis_sample_dropper_ram.sv
// ----------------------------------------------------------------------------
// axis_sample_dropper_ram
// Simple dual-port register array backing the sample FIFO. One synchronous
// write port, one asynchronous read port, sized for distributed RAM.
//
// Ports:
//   i_clk    write clock (rising edge)
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  read data, combinational from i_raddr
// ----------------------------------------------------------------------------
module axis_sample_dropper_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   // No reset on the array: contents are only observable behind a valid
   // pointer range, so stale data is never presented.
   logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axis_sample_dropper.sv
// ----------------------------------------------------------------------------
// axis_sample_dropper
// Takes a free-running (never stalled) AXI4-Stream and presents it to a
// consumer that may backpressure. A first-word-fall-through FIFO absorbs
// short stalls; when it is full, new samples are discarded, counted in a
// saturating drop counter and flagged in a sticky overflow bit.
//
// Ports:
//   aclk, areset      clock, asynchronous active-high reset
//   s_axis_*          upstream stream; tready is 1 whenever out of reset
//   m_axis_*          downstream stream; tdata is the FIFO head word
//   clear             synchronous clear of drop_count / overflow
//   drop_count        saturating count of discarded samples
//   overflow          sticky drop flag
//   fill_level        registered occupancy, 0..2**FIFO_ADDR_WIDTH
// ----------------------------------------------------------------------------
module axis_sample_dropper #(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int FIFO_ADDR_WIDTH  = 4,
   parameter int CNTR_WIDTH       = 32
) (
   input  logic                        aclk,
   input  logic                        areset,
   output logic                        s_axis_tready,
   input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                        s_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        clear,
   output logic [CNTR_WIDTH-1:0]       drop_count,
   output logic                        overflow,
   output logic [FIFO_ADDR_WIDTH:0]    fill_level
);

   // Pointers carry one extra wrap bit to tell full from empty.
   localparam int PW = FIFO_ADDR_WIDTH + 1;

   logic [PW-1:0]               r_wr_ptr, r_rd_ptr;
   logic [PW-1:0]               w_wr_nxt, w_rd_nxt;
   logic [PW-1:0]               r_fill;
   logic [CNTR_WIDTH-1:0]       r_drop_cnt;
   logic                        r_ovf;
   logic                        w_empty, w_full, w_rd, w_wr, w_drop;
   logic [AXIS_TDATA_WIDTH-1:0] w_rd_data;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                    (r_wr_ptr[PW-2:0] == r_rd_ptr[PW-2:0]);

   // A read in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_rd   = !w_empty && m_axis_tready;
   assign w_drop = s_axis_tvalid && w_full && !w_rd;
   assign w_wr   = s_axis_tvalid && !w_drop;

   assign w_wr_nxt = r_wr_ptr + {{(PW-1){1'b0}}, w_wr};
   assign w_rd_nxt = r_rd_ptr + {{(PW-1){1'b0}}, w_rd};

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
      end else begin
         r_wr_ptr <= w_wr_nxt;
         r_rd_ptr <= w_rd_nxt;
         r_fill   <= w_wr_nxt - w_rd_nxt;
      end
   end

   // A drop coinciding with clear is kept as the first event of the new
   // accounting window instead of being lost.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_drop_cnt <= '0;
         r_ovf      <= 1'b0;
      end else if (clear) begin
         r_drop_cnt <= {{(CNTR_WIDTH-1){1'b0}}, w_drop};
         r_ovf      <= w_drop;
      end else if (w_drop) begin
         if (!(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + 1'b1;
         r_ovf <= 1'b1;
      end
   end

   axis_sample_dropper_ram #(
      .DATA_WIDTH (AXIS_TDATA_WIDTH),
      .ADDR_WIDTH (FIFO_ADDR_WIDTH)
   ) u_ram (
      .i_clk   (aclk),
      .i_we    (w_wr),
      .i_waddr (r_wr_ptr[PW-2:0]),
      .i_wdata (s_axis_tdata),
      .i_raddr (r_rd_ptr[PW-2:0]),
      .o_rdata (w_rd_data)
   );

   assign s_axis_tready = !areset;
   assign m_axis_tvalid = !w_empty;
   // Mask the unreset array so tdata reads 0 whenever nothing is held.
   assign m_axis_tdata  = w_empty ? '0 : w_rd_data;
   assign drop_count    = r_drop_cnt;
   assign overflow      = r_ovf;
   assign fill_level    = r_fill;

endmodule

// File: tb/tb_axis_sample_dropper.sv
module tb_axis_sample_dropper;

   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int CW    = 4;
   localparam int DEPTH = 16;

   logic          aclk = 1'b0;
   logic          areset;
   logic          s_axis_tready;
   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tvalid;
   logic          m_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          clear;
   logic [CW-1:0] drop_count;
   logic          overflow;
   logic [AW:0]   fill_level;

   int n_cmp = 0;
   int n_err = 0;

   axis_sample_dropper #(
      .AXIS_TDATA_WIDTH (DW),
      .FIFO_ADDR_WIDTH  (AW),
      .CNTR_WIDTH       (CW)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .clear         (clear),
      .drop_count    (drop_count),
      .overflow      (overflow),
      .fill_level    (fill_level)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a bounded queue of accepted samples plus drop stats.
   logic [DW-1:0] exp_q[$];
   int            mlev;
   int            mcnt;
   bit            movf;

   always @(posedge aclk or posedge areset) begin
      if (areset) begin
         exp_q.delete();
         mlev <= 0;
         mcnt <= 0;
         movf <= 1'b0;
      end else begin
         automatic bit rd   = (mlev > 0) && m_axis_tready;
         automatic bit drop = s_axis_tvalid && (mlev == DEPTH) && !rd;
         automatic bit wr   = s_axis_tvalid && !drop;
         if (wr) exp_q.push_back(s_axis_tdata);
         mlev <= mlev - int'(rd) + int'(wr);
         if (clear) begin
            mcnt <= drop ? 1 : 0;
            movf <= drop;
         end else if (drop) begin
            mcnt <= (mcnt == (1 << CW) - 1) ? mcnt : mcnt + 1;
            movf <= 1'b1;
         end
      end
   end

   // Monitor: compares observable state and pops the scoreboard on handshakes.
   always @(negedge aclk) begin
      chk("s_tready", 64'(s_axis_tready), 64'(!areset));
      chk("m_tvalid", 64'(m_axis_tvalid), 64'(mlev != 0));
      chk("fill_level", 64'(fill_level), 64'(mlev));
      chk("drop_count", 64'(drop_count), 64'(mcnt));
      chk("overflow", 64'(overflow), 64'(movf));
      if (areset) chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
      if (!areset && m_axis_tvalid && m_axis_tready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL m_tdata: got %0h expected no word at %0t", m_axis_tdata, $time);
         end else begin
            chk("m_tdata", 64'(m_axis_tdata), 64'(exp_q[0]));
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic cyc();
      @(posedge aclk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [DW-1:0] d);
      s_axis_tvalid = v;
      s_axis_tdata  = d;
   endtask

   initial begin
      areset = 1'b1;
      clear  = 1'b0;
      m_axis_tready = 1'b0;
      drive(0, '0);
      repeat (3) cyc();
      areset = 1'b0;

      // Streaming straight through
      m_axis_tready = 1'b1;
      for (int i = 1; i <= 30; i++) begin drive(1, DW'(i)); cyc(); end
      drive(0, '0);
      repeat (2) cyc();

      // 20-cycle stall: 16 stored, 4 dropped
      m_axis_tready = 1'b0;
      for (int i = 0; i < 20; i++) begin drive(1, DW'(100 + i)); cyc(); end
      drive(0, '0);
      @(negedge aclk);
      chk("stall_fill", 64'(fill_level), 64'd16);
      chk("stall_drops", 64'(drop_count), 64'd4);
      chk("stall_ovf", 64'(overflow), 64'd1);
      cyc();
      m_axis_tready = 1'b1;
      repeat (18) cyc();
      clear = 1'b1; cyc(); clear = 1'b0;

      // Full FIFO with continuous read and write across pointer wrap
      m_axis_tready = 1'b0;
      for (int i = 0; i < 16; i++) begin drive(1, DW'(200 + i)); cyc(); end
      m_axis_tready = 1'b1;
      for (int i = 0; i < 100; i++) begin drive(1, DW'(300 + i)); cyc(); end
      @(negedge aclk);
      chk("wrap_fill", 64'(fill_level), 64'd16);
      chk("wrap_drops", 64'(drop_count), 64'd0);

      // Clear colliding with a drop, then clear alone
      cyc();
      m_axis_tready = 1'b0;
      drive(1, 32'hDEAD_0001);
      clear = 1'b1;
      cyc();
      drive(0, '0);
      @(negedge aclk);
      chk("clr_drop_cnt", 64'(drop_count), 64'd1);
      chk("clr_drop_ovf", 64'(overflow), 64'd1);
      cyc();
      clear = 1'b0;
      @(negedge aclk);
      chk("clr_cnt", 64'(drop_count), 64'd0);
      chk("clr_ovf", 64'(overflow), 64'd0);
      chk("clr_fill", 64'(fill_level), 64'd16);

      // Saturation with 20 drops on a 4-bit counter
      cyc();
      for (int i = 0; i < 20; i++) begin drive(1, DW'(600 + i)); cyc(); end
      drive(0, '0);
      @(negedge aclk);
      chk("sat_cnt", 64'(drop_count), 64'd15);
      cyc();
      m_axis_tready = 1'b1;
      repeat (18) cyc();

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         drive(($urandom % 4) != 0, $urandom);
         m_axis_tready = ($urandom % 3) != 0;
         clear = ($urandom % 50) == 0;
         cyc();
      end
      clear = 1'b0;
      drive(0, '0);
      m_axis_tready = 1'b1;
      repeat (18) cyc();

      // Reset mid-stream with 10 words stored
      m_axis_tready = 1'b0;
      for (int i = 0; i < 10; i++) begin drive(1, DW'(700 + i)); cyc(); end
      drive(0, '0);
      @(negedge aclk);
      chk("pre_rst_fill", 64'(fill_level), 64'd10);
      cyc();
      areset = 1'b1;
      #1;
      chk("rst_async_vld", 64'(m_axis_tvalid), 64'd0);
      cyc();
      areset = 1'b0;
      m_axis_tready = 1'b1;
      for (int i = 0; i < 5; i++) begin drive(1, DW'(800 + i)); cyc(); end
      drive(0, '0);
      repeat (4) cyc();
      chk("post_rst_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
